// File: rtl/snitch_sb_pkg.sv
// Shared scoreboard definitions: ID width derivation and protocol-error causes
// for the scoreboard ID pool and its retirement tracker.
package snitch_sb_pkg;

   function automatic int unsigned sb_id_width(input int unsigned depth);
      return (depth > 32'd1) ? $clog2(depth) : 32'd1;
   endfunction

   typedef enum logic [1:0] {
      SbErrNone     = 2'd0,
      SbErrOverflow = 2'd1,
      SbErrUnheld   = 2'd2,
      SbErrDup      = 2'd3
   } sb_err_e;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH so any
// depth (including non-powers of two) is supported.
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned ADDR_DEPTH   = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_DEPTH-1:0] usage_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam logic [ADDR_DEPTH:0]   CntFull  = (ADDR_DEPTH+1)'(DEPTH);
   localparam logic [ADDR_DEPTH:0]   CntZero  = {(ADDR_DEPTH+1){1'b0}};
   localparam logic [ADDR_DEPTH-1:0] LastAddr = ADDR_DEPTH'(DEPTH - 32'd1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR_DEPTH-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
   logic [ADDR_DEPTH:0]   count_r, count_nxt_s;
   logic                  bypass_s, push_ok_s, pop_ok_s, write_s;

   function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] ptr);
      return (ptr == LastAddr) ? {ADDR_DEPTH{1'b0}} : ptr + ADDR_DEPTH'(1);
   endfunction

   assign bypass_s  = FALL_THROUGH && (count_r == CntZero) && push_i;
   assign full_o    = (count_r == CntFull);
   assign empty_o   = (count_r == CntZero) && !bypass_s;
   assign usage_o   = count_r[ADDR_DEPTH-1:0];
   assign data_o    = bypass_s ? data_i : mem_r[rd_ptr_r];
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;
   assign write_s   = push_ok_s && !(bypass_s && pop_i);

   // Next-state pointers and count; a bypassed push+pop leaves storage untouched.
   always_comb begin
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      count_nxt_s  = count_r;
      if (bypass_s && pop_i) begin
         count_nxt_s = count_r;
      end else begin
         if (push_ok_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + (ADDR_DEPTH+1)'(1);
            2'b01:   count_nxt_s = count_r - (ADDR_DEPTH+1)'(1);
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // Pointer, count and storage registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_r <= {ADDR_DEPTH{1'b0}};
         wr_ptr_r <= {ADDR_DEPTH{1'b0}};
         count_r  <= CntZero;
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
      end else if (flush_i) begin
         rd_ptr_r <= {ADDR_DEPTH{1'b0}};
         wr_ptr_r <= {ADDR_DEPTH{1'b0}};
         count_r  <= CntZero;
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         count_r  <= count_nxt_s;
         if (write_s) mem_r[wr_ptr_r] <= data_i;
      end
   end

endmodule

// File: rtl/snitch_sb_retire.sv
// In-order retirement tracker: records IDs in issue order, accepts out-of-order
// completions and hands IDs back to the free pool strictly in issue order.
module snitch_sb_retire
   import snitch_sb_pkg::*;
#(
   parameter int unsigned Depth   = 8,
   parameter int unsigned IdWidth = sb_id_width(Depth)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               alloc_valid_i,
   input  logic [IdWidth-1:0] alloc_id_i,
   output logic               alloc_ready_o,
   input  logic               done_valid_i,
   input  logic [IdWidth-1:0] done_id_i,
   output logic               release_valid_o,
   output logic [IdWidth-1:0] release_id_o,
   input  logic               release_ready_i,
   output logic [IdWidth:0]   outstanding_o,
   output logic [Depth-1:0]   pending_o,
   output logic               empty_o,
   output logic               err_o
);

   typedef logic [IdWidth-1:0] sb_id_t;

   logic             fifo_full_s, fifo_empty_s;
   sb_id_t           usage_s, head_id_s;
   logic             push_s, pop_s, done_ok_s;
   logic [Depth-1:0] pending_r, done_r, pending_nxt_s, done_nxt_s;
   sb_err_e          err_cause_s;
   logic             err_r;

   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   (IdWidth),
      .DEPTH        (Depth)
   ) i_order_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .usage_o (usage_s),
      .data_i  (alloc_id_i),
      .push_i  (push_s),
      .data_o  (head_id_s),
      .pop_i   (pop_s)
   );

   assign alloc_ready_o   = !fifo_full_s;
   assign push_s          = alloc_valid_i && !fifo_full_s;
   // Release depends only on registered state, giving a fixed done->release latency.
   assign release_valid_o = !fifo_empty_s && done_r[head_id_s];
   assign release_id_o    = fifo_empty_s ? {IdWidth{1'b0}} : head_id_s;
   assign pop_s           = release_valid_o && release_ready_i;
   assign done_ok_s       = done_valid_i && pending_r[done_id_i] && !done_r[done_id_i];
   assign outstanding_o   = fifo_full_s ? (IdWidth+1)'(Depth) : {1'b0, usage_s};
   assign empty_o         = fifo_empty_s;
   assign pending_o       = pending_r;
   assign err_o           = err_r;

   // Classify protocol errors against the registered bitmaps.
   always_comb begin
      err_cause_s = SbErrNone;
      if (alloc_valid_i && fifo_full_s) begin
         err_cause_s = SbErrOverflow;
      end else if (done_valid_i && !pending_r[done_id_i]) begin
         err_cause_s = SbErrUnheld;
      end else if (done_valid_i && done_r[done_id_i]) begin
         err_cause_s = SbErrDup;
      end else begin
         err_cause_s = SbErrNone;
      end
   end

   // Bitmap updates: release clears the head, then alloc/done set their IDs.
   always_comb begin
      pending_nxt_s = pending_r;
      done_nxt_s    = done_r;
      if (pop_s) begin
         pending_nxt_s[head_id_s] = 1'b0;
         done_nxt_s[head_id_s]    = 1'b0;
      end else begin
         pending_nxt_s = pending_r;
      end
      if (push_s) begin
         pending_nxt_s[alloc_id_i] = 1'b1;
      end else begin
         done_nxt_s = done_nxt_s;
      end
      if (done_ok_s) begin
         done_nxt_s[done_id_i] = 1'b1;
      end else begin
         done_nxt_s = done_nxt_s;
      end
   end

   // Bitmap and sticky error registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_r <= {Depth{1'b0}};
         done_r    <= {Depth{1'b0}};
         err_r     <= 1'b0;
      end else begin
         pending_r <= pending_nxt_s;
         done_r    <= done_nxt_s;
         err_r     <= err_r || (err_cause_s != SbErrNone);
      end
   end

endmodule

// File: tb/tb_snitch_sb_retire.sv
// Directed checks of snitch_sb_retire (Depth=8) plus a Depth=5 closed loop
// against a behavioural free-pool model.
module tb_snitch_sb_retire;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Depth=8 instance
   logic       d_av, d_ar, d_dv, d_rv, d_rr, d_empty, d_err;
   logic [2:0] d_aid, d_did, d_rid;
   logic [3:0] d_out;
   logic [7:0] d_pend;

   // Depth=5 instance
   logic       c_av, c_ar, c_dv, c_rv, c_rr, c_empty, c_err;
   logic [2:0] c_aid, c_did, c_rid;
   logic [3:0] c_out;
   logic [4:0] c_pend;

   int pool_q[$];
   int order_q[$];
   int nd_q[$];

   snitch_sb_retire #(.Depth(8)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .alloc_valid_i(d_av), .alloc_id_i(d_aid), .alloc_ready_o(d_ar),
      .done_valid_i(d_dv), .done_id_i(d_did),
      .release_valid_o(d_rv), .release_id_o(d_rid), .release_ready_i(d_rr),
      .outstanding_o(d_out), .pending_o(d_pend), .empty_o(d_empty), .err_o(d_err)
   );

   snitch_sb_retire #(.Depth(5)) dut5 (
      .clk_i(clk), .rst_ni(rst_n),
      .alloc_valid_i(c_av), .alloc_id_i(c_aid), .alloc_ready_o(c_ar),
      .done_valid_i(c_dv), .done_id_i(c_did),
      .release_valid_o(c_rv), .release_id_o(c_rid), .release_ready_i(c_rr),
      .outstanding_o(c_out), .pending_o(c_pend), .empty_o(c_empty), .err_o(c_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [2:0] aid, input logic dv,
                        input logic [2:0] did, input logic rr);
      d_av = av; d_aid = aid; d_dv = dv; d_did = did; d_rr = rr;
   endtask

   task automatic do_reset();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      c_av = 1'b0; c_aid = 3'd0; c_dv = 1'b0; c_did = 3'd0; c_rr = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (d_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", d_empty); end
      tests++; if (d_rv !== 1'b0) begin fails++; $display("FAIL reset_rv got %b want 0", d_rv); end
      tests++; if (d_out !== 4'd0) begin fails++; $display("FAIL reset_out got %0d want 0", d_out); end
      tests++; if (d_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", d_err); end
      tests++; if (d_pend !== 8'h00) begin fails++; $display("FAIL reset_pend got %h want 00", d_pend); end
      tests++; if (d_ar !== 1'b1) begin fails++; $display("FAIL reset_ar got %b want 1", d_ar); end
      tests++; if (d_rid !== 3'd0) begin fails++; $display("FAIL reset_rid got %0d want 0", d_rid); end
   endtask

   task automatic test_in_order();
      do_reset();
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b1); step();
      tests++; if (d_out !== 4'd1 || d_pend !== 8'h01 || d_rv !== 1'b0) begin
         fails++; $display("FAIL io_alloc0 got out=%0d pend=%h rv=%b want 1/01/0", d_out, d_pend, d_rv);
      end
      drive(1'b1, 3'd1, 1'b0, 3'd0, 1'b1); step();
      drive(1'b1, 3'd2, 1'b0, 3'd0, 1'b1); step();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1); step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 3'd0, 1'b1, 3'(i), 1'b1); step();
         tests++; if (d_rv !== 1'b1 || d_rid !== 3'(i)) begin
            fails++; $display("FAIL io_release%0d got rv=%b id=%0d want 1/%0d", i, d_rv, d_rid, i);
         end
      end
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1); step();
      tests++; if (d_out !== 4'd0 || d_empty !== 1'b1 || d_rv !== 1'b0 || d_err !== 1'b0) begin
         fails++; $display("FAIL io_drained got out=%0d empty=%b rv=%b err=%b want 0/1/0/0", d_out, d_empty, d_rv, d_err);
      end
   endtask

   task automatic test_out_of_order();
      logic [2:0] exp_ids [3];
      exp_ids[0] = 3'd3; exp_ids[1] = 3'd5; exp_ids[2] = 3'd7;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, exp_ids[i], 1'b0, 3'd0, 1'b1); step();
      end
      drive(1'b0, 3'd0, 1'b1, 3'd7, 1'b1); step();
      drive(1'b0, 3'd0, 1'b1, 3'd5, 1'b1); step();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1); step();
      tests++; if (d_rv !== 1'b0 || d_out !== 4'd3 || d_pend !== 8'hA8 || d_rid !== 3'd3) begin
         fails++; $display("FAIL ooo_blocked got rv=%b out=%0d pend=%h rid=%0d want 0/3/a8/3", d_rv, d_out, d_pend, d_rid);
      end
      drive(1'b0, 3'd0, 1'b1, 3'd3, 1'b1); step();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tests++; if (d_rv !== 1'b1 || d_rid !== exp_ids[i]) begin
            fails++; $display("FAIL ooo_release%0d got rv=%b id=%0d want 1/%0d", i, d_rv, d_rid, exp_ids[i]);
         end
         step();
      end
      tests++; if (d_empty !== 1'b1 || d_pend !== 8'h00 || d_err !== 1'b0) begin
         fails++; $display("FAIL ooo_drained got empty=%b pend=%h err=%b want 1/00/0", d_empty, d_pend, d_err);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'(i), 1'b0, 3'd0, 1'b0); step();
      end
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      tests++; if (d_ar !== 1'b0 || d_out !== 4'd8 || d_pend !== 8'hFF) begin
         fails++; $display("FAIL full_state got ar=%b out=%0d pend=%h want 0/8/ff", d_ar, d_out, d_pend);
      end
      drive(1'b0, 3'd0, 1'b1, 3'd0, 1'b0); step();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tests++; if (d_rv !== 1'b1 || d_rid !== 3'd0 || d_out !== 4'd8) begin
            fails++; $display("FAIL full_hold%0d got rv=%b id=%0d out=%0d want 1/0/8", i, d_rv, d_rid, d_out);
         end
         step();
      end
      tests++; if (d_err !== 1'b0) begin fails++; $display("FAIL full_noerr got %b want 0", d_err); end
      drive(1'b1, 3'd3, 1'b0, 3'd0, 1'b0); step();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      tests++; if (d_err !== 1'b1 || d_out !== 4'd8 || d_pend !== 8'hFF) begin
         fails++; $display("FAIL full_overflow got err=%b out=%0d pend=%h want 1/8/ff", d_err, d_out, d_pend);
      end
   endtask

   task automatic test_errors();
      do_reset();
      drive(1'b1, 3'd2, 1'b0, 3'd0, 1'b0); step();
      drive(1'b0, 3'd0, 1'b1, 3'd4, 1'b0); step();
      tests++; if (d_err !== 1'b1 || d_pend !== 8'h04 || d_rv !== 1'b0) begin
         fails++; $display("FAIL err_unheld got err=%b pend=%h rv=%b want 1/04/0", d_err, d_pend, d_rv);
      end
      do_reset();
      drive(1'b1, 3'd2, 1'b0, 3'd0, 1'b0); step();
      drive(1'b0, 3'd0, 1'b1, 3'd2, 1'b0); step();
      tests++; if (d_err !== 1'b0 || d_rv !== 1'b1) begin
         fails++; $display("FAIL err_firstdone got err=%b rv=%b want 0/1", d_err, d_rv);
      end
      drive(1'b0, 3'd0, 1'b1, 3'd2, 1'b0); step();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step();
      tests++; if (d_err !== 1'b1 || d_pend !== 8'h04) begin
         fails++; $display("FAIL err_dup_sticky got err=%b pend=%h want 1/04", d_err, d_pend);
      end
      do_reset();
      drive(1'b1, 3'd6, 1'b1, 3'd6, 1'b0); step();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      tests++; if (d_err !== 1'b1 || d_pend !== 8'h40 || d_rv !== 1'b0) begin
         fails++; $display("FAIL err_same_cycle got err=%b pend=%h rv=%b want 1/40/0", d_err, d_pend, d_rv);
      end
      do_reset();
      drive(1'b1, 3'd1, 1'b0, 3'd0, 1'b0); step();
      drive(1'b0, 3'd0, 1'b1, 3'd1, 1'b0); step();
      drive(1'b0, 3'd0, 1'b1, 3'd1, 1'b1); step();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      tests++; if (d_err !== 1'b1 || d_out !== 4'd0 || d_pend !== 8'h00) begin
         fails++; $display("FAIL err_head_release got err=%b out=%0d pend=%h want 1/0/00", d_err, d_out, d_pend);
      end
   endtask

   task automatic test_back_to_back_alloc_release();
      do_reset();
      drive(1'b1, 3'd4, 1'b0, 3'd0, 1'b1); step();
      drive(1'b0, 3'd0, 1'b1, 3'd4, 1'b1); step();
      drive(1'b1, 3'd5, 1'b0, 3'd0, 1'b1); step();
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      tests++; if (d_out !== 4'd1 || d_pend !== 8'h20 || d_rid !== 3'd5 || d_rv !== 1'b0) begin
         fails++; $display("FAIL b2b_alloc_rel got out=%0d pend=%h rid=%0d rv=%b want 1/20/5/0", d_out, d_pend, d_rid, d_rv);
      end
   endtask

   task automatic test_closed_loop();
      int  aid, k;
      bit  do_rel, do_alloc, dup;
      logic [2:0] rid;
      do_reset();
      pool_q.delete(); order_q.delete(); nd_q.delete();
      for (int i = 0; i < 5; i++) pool_q.push_back(i);
      for (int cyc = 0; cyc < 1000; cyc++) begin
         aid = 0;
         c_rr = ($urandom_range(3) != 0);
         do_rel = c_rv && c_rr;
         rid = c_rid;
         do_alloc = (pool_q.size() > 0) && c_ar && ($urandom_range(1) == 1);
         c_av = do_alloc;
         if (do_alloc) begin aid = pool_q.pop_front(); c_aid = 3'(aid); end
         c_dv = 1'b0;
         if (nd_q.size() > 0 && $urandom_range(1) == 1) begin
            k = $urandom_range(nd_q.size() - 1);
            c_dv = 1'b1; c_did = 3'(nd_q[k]);
            nd_q.delete(k);
         end
         step();
         if (do_rel) begin
            tests++;
            if (order_q.size() == 0 || int'(rid) != order_q[0]) begin
               fails++; $display("FAIL loop_order cyc=%0d got %0d want %0d", cyc, rid, (order_q.size() > 0) ? order_q[0] : -1);
            end
            if (order_q.size() > 0) void'(order_q.pop_front());
            dup = 1'b0;
            foreach (pool_q[j]) if (pool_q[j] == int'(rid)) dup = 1'b1;
            tests++; if (dup) begin fails++; $display("FAIL loop_dup cyc=%0d got id %0d already free want unique", cyc, rid); end
            pool_q.push_back(int'(rid));
         end
         if (do_alloc) begin order_q.push_back(aid); nd_q.push_back(aid); end
         tests++; if (pool_q.size() + int'(c_out) != 5) begin
            fails++; $display("FAIL loop_conserve cyc=%0d got %0d want 5", cyc, pool_q.size() + int'(c_out));
         end
         tests++; if ($countones(c_pend) != int'(c_out)) begin
            fails++; $display("FAIL loop_popcount cyc=%0d got %0d want %0d", cyc, $countones(c_pend), c_out);
         end
      end
      c_av = 1'b0; c_dv = 1'b0;
      tests++; if (c_err !== 1'b0) begin fails++; $display("FAIL loop_err got %b want 0", c_err); end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_out_of_order();
      test_full();
      test_errors();
      test_back_to_back_alloc_release();
      test_closed_loop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
